// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: reads N activation/weight pairs from the neuron RAM,
// accumulates their unsigned dot product, then writes a scaled, saturated byte back.
module neuron_mac_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int X_BASE   = 0,
  parameter int W_BASE   = 4,
  parameter int OUT_ADDR = 8,
  parameter int SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] ram_read_address,
  output logic       ram_oe,
  input  logic [7:0] ram_read_data,
  output logic [7:0] ram_write_address,
  output logic [7:0] ram_write_data,
  output logic       ram_wre
);

  typedef enum logic [2:0] {
    IDLE,
    RD_X,
    RD_W,
    WRITE,
    DONE
  } state_t;

  localparam logic [5:0] LAST_IDX   = 6'(N_INPUTS - 1);
  localparam logic [7:0] X_BASE_A   = 8'(X_BASE);
  localparam logic [7:0] W_BASE_A   = 8'(W_BASE);
  localparam logic [7:0] OUT_ADDR_A = 8'(OUT_ADDR);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  logic [7:0]  x_reg_q, x_reg_d;
  logic [7:0]  result_q, result_d;

  logic [15:0] product;
  logic [23:0] scaled;
  logic [7:0]  sat_value;

  // Saturated output is derived purely from the registered accumulator.
  always_comb begin
    product   = x_reg_q * ram_read_data;
    scaled    = acc_q >> SHIFT;
    sat_value = (scaled > 24'd255) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      x_reg_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      x_reg_q  <= x_reg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    acc_d             = acc_q;
    x_reg_d           = x_reg_q;
    result_d          = result_q;
    busy              = 1'b0;
    done              = 1'b0;
    ram_read_address  = '0;
    ram_oe            = 1'b0;
    ram_write_address = '0;
    ram_write_data    = '0;
    ram_wre           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = RD_X;
        end
      end
      RD_X: begin
        busy             = 1'b1;
        ram_oe           = 1'b1;
        ram_read_address = X_BASE_A + {2'b00, idx_q};
        x_reg_d          = ram_read_data;
        state_d          = RD_W;
      end
      RD_W: begin
        busy             = 1'b1;
        ram_oe           = 1'b1;
        ram_read_address = W_BASE_A + {2'b00, idx_q};
        acc_d            = acc_q + {8'h00, product};
        if (idx_q == LAST_IDX) begin
          state_d = WRITE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = RD_X;
        end
      end
      WRITE: begin
        busy              = 1'b1;
        ram_wre           = 1'b1;
        ram_write_address = OUT_ADDR_A;
        ram_write_data    = sat_value;
        result_d          = sat_value;
        state_d           = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer: three instances (default, SHIFT=2,
// N_INPUTS=1) share one RAM model; expected reads, writes and results are queued at start.
module tb_neuron_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic startReq;
  int   sel;
  int   cycleCount = 0;
  int   doneCount = 0;
  int   vecCount = 0;
  int   errCount = 0;

  logic [7:0] mem [0:255];

  logic       busy0, done0, oe0, wre0;
  logic [7:0] res0, ra0, rd0, wa0, wd0;
  logic       busy1, done1, oe1, wre1;
  logic [7:0] res1, ra1, rd1, wa1, wd1;
  logic       busy2, done2, oe2, wre2;
  logic [7:0] res2, ra2, rd2, wa2, wd2;

  logic       monBusy, monDone, monOe, monWre;
  logic [7:0] monRes, monRa, monWa, monWd;

  int expAddr[$];
  int expWrData[$];
  int expWrCycle[$];
  int expDoneCycle[$];
  int expResult[$];
  int monE;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Shared RAM model: only one instance is ever active, so writes never collide.
  always @(posedge clk) begin
    if (wre0) mem[wa0] = wd0;
    if (wre1) mem[wa1] = wd1;
    if (wre2) mem[wa2] = wd2;
  end

  assign rd0 = oe0 ? mem[ra0] : 8'h00;
  assign rd1 = oe1 ? mem[ra1] : 8'h00;
  assign rd2 = oe2 ? mem[ra2] : 8'h00;

  neuron_mac_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(startReq && sel == 0),
    .busy(busy0), .done(done0), .result(res0),
    .ram_read_address(ra0), .ram_oe(oe0), .ram_read_data(rd0),
    .ram_write_address(wa0), .ram_write_data(wd0), .ram_wre(wre0)
  );

  neuron_mac_sequencer #(.SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startReq && sel == 1),
    .busy(busy1), .done(done1), .result(res1),
    .ram_read_address(ra1), .ram_oe(oe1), .ram_read_data(rd1),
    .ram_write_address(wa1), .ram_write_data(wd1), .ram_wre(wre1)
  );

  neuron_mac_sequencer #(.N_INPUTS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(startReq && sel == 2),
    .busy(busy2), .done(done2), .result(res2),
    .ram_read_address(ra2), .ram_oe(oe2), .ram_read_data(rd2),
    .ram_write_address(wa2), .ram_write_data(wd2), .ram_wre(wre2)
  );

  assign monBusy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign monDone = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign monOe   = (sel == 0) ? oe0   : (sel == 1) ? oe1   : oe2;
  assign monWre  = (sel == 0) ? wre0  : (sel == 1) ? wre1  : wre2;
  assign monRes  = (sel == 0) ? res0  : (sel == 1) ? res1  : res2;
  assign monRa   = (sel == 0) ? ra0   : (sel == 1) ? ra1   : ra2;
  assign monWa   = (sel == 0) ? wa0   : (sel == 1) ? wa1   : wa2;
  assign monWd   = (sel == 0) ? wd0   : (sel == 1) ? wd1   : wd2;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  // Monitor: every read, write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (monOe) begin
        if (expAddr.size() == 0) begin
          checkOutput("spurious_oe", int'(monOe), 0);
        end else begin
          monE = expAddr.pop_front();
          checkOutput("rd_addr", int'(monRa), monE);
          checkOutput("busy_rd", int'(monBusy), 1);
        end
      end
      if (monWre) begin
        if (expWrData.size() == 0) begin
          checkOutput("spurious_wre", int'(monWre), 0);
        end else begin
          checkOutput("wr_addr", int'(monWa), 8);
          monE = expWrData.pop_front();
          checkOutput("wr_data", int'(monWd), monE);
          monE = expWrCycle.pop_front();
          checkOutput("wr_cycle", cycleCount, monE);
          expDoneCycle.push_back(monE + 1);
          checkOutput("busy_wr", int'(monBusy), 1);
        end
      end
      if (monDone) begin
        doneCount++;
        if (expDoneCycle.size() == 0) begin
          checkOutput("spurious_done", int'(monDone), 0);
        end else begin
          monE = expDoneCycle.pop_front();
          checkOutput("done_cycle", cycleCount, monE);
          monE = expResult.pop_front();
          checkOutput("result", int'(monRes), monE);
          checkOutput("busy_done", int'(monBusy), 0);
        end
      end
    end
  end

  task automatic waitDone(input int target);
    int k;
    k = 0;
    while (doneCount < target && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (doneCount < target) checkOutput("done_timeout", doneCount, target);
  endtask

  task automatic loadOperands(input int x0, input int x1, input int x2, input int x3,
                              input int w0, input int w1, input int w2, input int w3);
    mem[0] = 8'(x0); mem[1] = 8'(x1); mem[2] = 8'(x2); mem[3] = 8'(x3);
    mem[4] = 8'(w0); mem[5] = 8'(w1); mem[6] = 8'(w2); mem[7] = 8'(w3);
  endtask

  task automatic queueRun(input int n, input int expVal);
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(i);
      expAddr.push_back(4 + i);
    end
    expWrData.push_back(expVal);
    expResult.push_back(expVal);
  endtask

  task automatic applyStimulus(input int dut, input int n, input int expVal);
    int target;
    @(negedge clk);
    sel = dut;
    target = doneCount + 1;
    queueRun(n, expVal);
    startReq = 1'b1;
    @(posedge clk);
    #1;
    expWrCycle.push_back(cycleCount + 2 * n);
    startReq = 1'b0;
    waitDone(target);
  endtask

  initial begin
    int c0;
    int target;
    rst_n    = 1'b0;
    startReq = 1'b0;
    sel      = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    #22;
    checkOutput("rst_busy", int'(busy0), 0);
    checkOutput("rst_done", int'(done0), 0);
    checkOutput("rst_result", int'(res0), 0);
    checkOutput("rst_oe", int'(oe0), 0);
    checkOutput("rst_wre", int'(wre0), 0);
    checkOutput("rst_raddr", int'(ra0), 0);
    checkOutput("rst_waddr", int'(wa0), 0);
    checkOutput("rst_wdata", int'(wd0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic dot product");
    loadOperands(10, 10, 11, 11, 2, 3, 2, 3);
    applyStimulus(0, 4, 105);
    checkOutput("mem8_basic", int'(mem[8]), 105);

    $display("[TB] shifted output");
    applyStimulus(1, 4, 26);
    checkOutput("mem8_shift", int'(mem[8]), 26);

    $display("[TB] start held high");
    @(negedge clk);
    sel = 0;
    target = doneCount + 3;
    for (int r = 0; r < 3; r++) queueRun(4, 105);
    startReq = 1'b1;
    @(posedge clk);
    #1;
    c0 = cycleCount;
    expWrCycle.push_back(c0 + 8);
    expWrCycle.push_back(c0 + 19);
    expWrCycle.push_back(c0 + 30);
    waitDone(target);
    startReq = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("idle_after_hold", int'(busy0), 0);
    checkOutput("hold_queue_empty", expAddr.size(), 0);

    $display("[TB] reset mid-operation");
    mem[8] = 8'hAA;
    @(negedge clk);
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      expAddr.push_back(i);
      expAddr.push_back(4 + i);
    end
    startReq = 1'b1;
    @(posedge clk);
    #1;
    c0 = cycleCount;
    startReq = 1'b0;
    while (cycleCount != c0 + 5 && cycleCount < c0 + 50) begin
      @(negedge clk);
      #1;
    end
    checkOutput("in_rdw", int'(oe0), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_oe", int'(oe0), 0);
    checkOutput("arst_wre", int'(wre0), 0);
    checkOutput("arst_busy", int'(busy0), 0);
    checkOutput("arst_done", int'(done0), 0);
    checkOutput("arst_result", int'(res0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mem8_unchanged", int'(mem[8]), 8'hAA);
    checkOutput("rst_queue_empty", expAddr.size(), 0);
    applyStimulus(0, 4, 105);
    checkOutput("mem8_after_rst", int'(mem[8]), 105);

    $display("[TB] saturation");
    loadOperands(255, 255, 255, 255, 255, 255, 255, 255);
    applyStimulus(0, 4, 255);
    checkOutput("mem8_sat", int'(mem[8]), 255);

    $display("[TB] single input");
    loadOperands(10, 0, 0, 0, 2, 0, 0, 0);
    applyStimulus(2, 1, 20);
    checkOutput("mem8_single", int'(mem[8]), 20);

    repeat (3) @(negedge clk);
    checkOutput("final_addr_queue", expAddr.size(), 0);
    checkOutput("final_wr_queue", expWrData.size(), 0);
    checkOutput("final_res_queue", expResult.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
